// File: rtl/prio_arbiter_pkg.sv
// Shared types and limits for the priority arbiter.
package prio_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 64;

endpackage

// File: rtl/prio_scan.sv
// Find-first-set searching downward from 'start', wrapping from bit 0 to bit N-1.
module prio_scan #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] index
);

    logic         low_found;
    logic [W-1:0] low_index;

    // The highest set bit at or below start wins; otherwise the search wraps
    // and the highest set bit overall (necessarily above start) wins.
    always_comb begin
        found     = 1'b0;
        index     = '0;
        low_found = 1'b0;
        low_index = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                index = W'(i);
                if (i <= int'(start)) begin
                    low_found = 1'b1;
                    low_index = W'(i);
                end
            end
        end
        if (low_found) begin
            index = low_index;
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Fixed-priority arbiter with held grants; define PRIO_ARBITER_RR_EN for round-robin.
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         valid
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("prio_arbiter: N out of range");
    end

    arb_state_t   state, state_n;
    logic [W-1:0] idx_n;
    logic [N-1:0] onehot_n;
    logic [W-1:0] start;
    logic         found;
    logic [W-1:0] scan_idx;

`ifdef PRIO_ARBITER_RR_EN
    logic [W-1:0] ptr, ptr_n, base;

    // On an accepting edge idx is about to become the pointer, so search from it directly.
    assign base  = (state == GRANT) ? idx : ptr;
    assign start = (base == '0) ? W'(N - 1) : base - W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_n;
        end
    end

    always_comb begin
        ptr_n = ptr;
        if (state == GRANT && ack) begin
            ptr_n = idx;
        end
    end
`else
    assign start = W'(N - 1);
`endif

    prio_scan #(.N(N), .W(W)) u_scan (
        .vec   (req),
        .start (start),
        .found (found),
        .index (scan_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            onehot <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            onehot <= onehot_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        onehot_n = onehot;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n  = GRANT;
                    idx_n    = scan_idx;
                    onehot_n = N'(1) << scan_idx;
                end else begin
                    idx_n    = '0;
                    onehot_n = '0;
                end
            end
            GRANT: begin
                if (ack) begin
                    if (found) begin
                        idx_n    = scan_idx;
                        onehot_n = N'(1) << scan_idx;
                    end else begin
                        state_n  = IDLE;
                        idx_n    = '0;
                        onehot_n = '0;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                idx_n    = '0;
                onehot_n = '0;
            end
        endcase
    end

    assign valid = (state == GRANT);

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter N, default 8, number of request lines; legal range 2..64.
REQ-002 Derived constant W = clog2(N), width of the encoded grant index; not overridable.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  N  request vector; bit i high means requester i wants service.
REQ-006 ack  input  1  consumer accepts the current grant; sampled only while valid is high.
REQ-007 idx  output W  registered encoded index of the granted requester.
REQ-008 onehot  output N  registered one-hot form of idx; all zero when valid is low.
REQ-009 valid  output 1  registered; high while a grant is held.

Function
REQ-010 The block SHALL have two states: IDLE (valid=0) and GRANT (valid=1).
REQ-011 In IDLE with req nonzero at a clock edge, the block SHALL enter GRANT and present the winner on idx/onehot in the next cycle (1-cycle latency).
REQ-012 In IDLE with req all zero, the block SHALL stay in IDLE with idx=0 and onehot=0.
REQ-013 In GRANT, idx/onehot/valid SHALL stay stable until ack is sampled high, regardless of req changes, including the winner dropping its request.
REQ-014 On ack in GRANT with req nonzero at that edge, the block SHALL present the next winner in the following cycle, with valid staying high (back-to-back, no bubble).
REQ-015 On ack in GRANT with req all zero, the block SHALL return to IDLE, with valid=0 and idx=0 in the following cycle.
REQ-016 The block SHALL ignore ack while valid is low.
REQ-017 Fixed priority: the highest set index of req SHALL win.
REQ-018 The winner SHALL be computed from req as sampled at the capturing edge only.

Reset
REQ-019 While rst is high at a clock edge, the block SHALL force state=IDLE, valid=0, idx=0, onehot=0 and last-grant pointer=0, overriding req and ack.
REQ-020 A reset asserted during GRANT SHALL discard the held grant without requiring ack.
REQ-021 In the first cycle after rst deasserts, the block SHALL be in IDLE and evaluate req normally.

Configuration
REQ-022 The block SHALL use the macro PRIO_ARBITER_RR_EN.
- Defined: round-robin mode.
  - A last-grant pointer (W bits) updates to idx on each accepted grant (ack while valid).
  - Search runs descending from (pointer-1) mod N, wrapping from 0 to N-1.
  - The first search after reset starts at N-1, so the first decision matches fixed priority.
- Undefined: fixed priority per REQ-017; no pointer register is synthesised.
REQ-023 Wrap-around SHALL be correct for N not a power of two; idx SHALL never exceed N-1.

Structure
REQ-024 Package prio_arbiter_pkg SHALL hold the state enum typedef (IDLE, GRANT) and the N range limits.
REQ-025 Sub-module prio_scan SHALL implement the combinational find-first-set.
- Inputs: vector and start index.
- Outputs: found flag and index.
- The top instantiates it once; fixed mode ties the start index to N-1.

Verification
REQ-026 Reset: N=8, req=8'hFF, rst high 2 cycles -> valid=0, idx=0, onehot=0 during reset; valid=1, idx=7 one cycle after release.
REQ-027 Hold: req=8'h24 in IDLE -> next cycle valid=1, idx=5, onehot=8'h20; then req=0 for 3 cycles with no ack -> idx=5 held; ack -> valid=0 next cycle.
REQ-028 Back-to-back: req=8'h24 held, ack at first grant -> next cycle valid stays 1; idx=2 (RR) or idx=5 (fixed).
REQ-029 RR wrap: grant idx=0 accepted, then req=8'h81 -> idx=7; ack -> idx=0; ack -> idx=7.
REQ-030 Spurious and mid-operation: ack pulsed in IDLE -> no state change; rst and ack high together in GRANT -> IDLE, pointer=0.
REQ-031 N=5: req=5'b10001 with RR, two successive accepts -> idx=4, then idx=0, then idx=4; idx never exceeds 4.
